// File: rtl/dp_byte_seq.sv
// dp_byte_seq: debug-port byte sequencer.
// Serializes a 32-bit word into four byte lanes over valid/ready.

module dp_mux (
  input  logic [31:0] datain,
  input  logic [1:0]  sel,
  output logic [7:0]  dataout
);

  // Lane select of one byte from the captured word
  always_comb begin
    dataout = 8'h00;
    unique case (sel)
      2'd0: dataout = datain[7:0];
      2'd1: dataout = datain[15:8];
      2'd2: dataout = datain[23:16];
      2'd3: dataout = datain[31:24];
      default: dataout = 8'h00;
    endcase
  end

endmodule

module dp_byte_seq #(
  parameter int MSB_FIRST = 0,
  parameter int GAP_CYC   = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [1:0]  sel,
  output logic        busy,
  output logic        done
);

  localparam int CW =
    (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [1:0] S_LANE =
    (MSB_FIRST != 0) ? 2'd3 : 2'd0;
  localparam logic [1:0] L_LANE =
    (MSB_FIRST != 0) ? 2'd0 : 2'd3;

  localparam logic [CW-1:0] GAP_LD =
    (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   word_q, word_d;
  logic [1:0]    sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [1:0]    sel_nx;

  // Lane stepping direction fixed by lane order
  always_comb begin
    sel_nx = (MSB_FIRST != 0) ? sel_q - 2'd1
                              : sel_q + 2'd1;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      word_q  <= '0;
      sel_q   <= S_LANE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state: capture, per-byte handshake, gap countdown
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (word_valid) begin
          word_d  = word_in;
          sel_d   = S_LANE;
          state_d = SEND;
        end
      end
      SEND: begin
        if (byte_ready) begin
          if (sel_q == L_LANE) begin
            done_d  = 1'b1;
            sel_d   = S_LANE;
            state_d = IDLE;
          end else if (GAP_CYC == 0) begin
            sel_d = sel_nx;
          end else begin
            cnt_d   = GAP_LD;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          sel_d   = sel_nx;
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = S_LANE;
      end
    endcase
  end

  // Outputs decode from registered state only
  always_comb begin
    word_ready = (state_q == IDLE);
    byte_valid = (state_q == SEND);
    busy       = (state_q != IDLE);
    done       = done_q;
    sel        = sel_q;
  end

  dp_mux u_mux (
    .datain  (word_q),
    .sel     (sel_q),
    .dataout (byte_out)
  );

endmodule

// File: tb/tb_dp_byte_seq.sv
// tb_dp_byte_seq: directed bench for dp_byte_seq.
// u0 LSB/no gap, u1 MSB first, u2 two-cycle gap.

module tb_dp_byte_seq;

  logic        clk;
  logic        resetn;
  logic [31:0] word_in;
  logic        word_valid;
  logic        byte_ready;

  logic        wr [3];
  logic [7:0]  bo [3];
  logic        bv [3];
  logic [1:0]  sl [3];
  logic        bz [3];
  logic        dn [3];

  int checks = 0;
  int errors = 0;

  dp_byte_seq #(.MSB_FIRST(0), .GAP_CYC(0)) u0 (
    .clk(clk), .resetn(resetn),
    .word_in(word_in), .word_valid(word_valid),
    .word_ready(wr[0]), .byte_out(bo[0]),
    .byte_valid(bv[0]), .byte_ready(byte_ready),
    .sel(sl[0]), .busy(bz[0]), .done(dn[0])
  );

  dp_byte_seq #(.MSB_FIRST(1), .GAP_CYC(0)) u1 (
    .clk(clk), .resetn(resetn),
    .word_in(word_in), .word_valid(word_valid),
    .word_ready(wr[1]), .byte_out(bo[1]),
    .byte_valid(bv[1]), .byte_ready(byte_ready),
    .sel(sl[1]), .busy(bz[1]), .done(dn[1])
  );

  dp_byte_seq #(.MSB_FIRST(0), .GAP_CYC(2)) u2 (
    .clk(clk), .resetn(resetn),
    .word_in(word_in), .word_valid(word_valid),
    .word_ready(wr[2]), .byte_out(bo[2]),
    .byte_valid(bv[2]), .byte_ready(byte_ready),
    .sel(sl[2]), .busy(bz[2]), .done(dn[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wv;
    logic [31:0] w;
    bit          br;
    bit          bv;
    logic [7:0]  bo;
    logic [1:0]  s;
    bit          dn;
    bit          rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    bit wv, logic [31:0] w, bit br,
    bit ebv, logic [7:0] ebo, logic [1:0] es,
    bit edn, bit erdy);
    vec_t v;
    v.wv = wv; v.w = w; v.br = br;
    v.bv = ebv; v.bo = ebo; v.s = es;
    v.dn = edn; v.rdy = erdy;
    return v;
  endfunction

  task automatic chk(string nm, int c,
                     logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h want %h",
               nm, c, act, exp);
    end
  endtask

  task automatic outs(int u, int c, vec_t v);
    chk($sformatf("u%0d.byte_valid", u), c, 32'(bv[u]), 32'(v.bv));
    chk($sformatf("u%0d.byte_out", u), c, 32'(bo[u]), 32'(v.bo));
    chk($sformatf("u%0d.sel", u), c, 32'(sl[u]), 32'(v.s));
    chk($sformatf("u%0d.done", u), c, 32'(dn[u]), 32'(v.dn));
    chk($sformatf("u%0d.word_ready", u), c, 32'(wr[u]), 32'(v.rdy));
    chk($sformatf("u%0d.busy", u), c, 32'(bz[u]), 32'(!v.rdy));
  endtask

  task automatic cyc(int u, int c, vec_t v);
    word_valid = v.wv;
    word_in    = v.w;
    byte_ready = v.br;
    outs(u, c, v);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    word_in    = '0;
    word_valid = 1'b0;
    byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // u0: basic word, stall, back-to-back
    tbl.push_back(mk(1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0, 1, 1, 8'hD4, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0, 1, 1, 8'hC3, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0, 1, 1, 8'hB2, 2, 0, 0));
    tbl.push_back(mk(0, 32'h0, 1, 1, 8'hA1, 3, 0, 0));
    tbl.push_back(mk(0, 32'h0, 1, 0, 8'hD4, 0, 1, 1));
    tbl.push_back(mk(1, 32'hCAFEBABE, 1, 0, 8'hD4, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0, 1, 1, 8'hBE, 0, 0, 0));
    tbl.push_back(mk(1, 32'hDEADDEAD, 0, 1, 8'hBA, 1, 0, 0));
    tbl.push_back(mk(1, 32'hDEADDEAD, 0, 1, 8'hBA, 1, 0, 0));
    tbl.push_back(mk(1, 32'hDEADDEAD, 0, 1, 8'hBA, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0, 1, 1, 8'hBA, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0, 1, 1, 8'hFE, 2, 0, 0));
    tbl.push_back(mk(0, 32'h0, 1, 1, 8'hCA, 3, 0, 0));
    tbl.push_back(mk(0, 32'h0, 1, 0, 8'hBE, 0, 1, 1));
    tbl.push_back(mk(1, 32'h01020304, 1, 0, 8'hBE, 0, 0, 1));
    tbl.push_back(mk(1, 32'h05060708, 1, 1, 8'h04, 0, 0, 0));
    tbl.push_back(mk(1, 32'h05060708, 1, 1, 8'h03, 1, 0, 0));
    tbl.push_back(mk(1, 32'h05060708, 1, 1, 8'h02, 2, 0, 0));
    tbl.push_back(mk(1, 32'h05060708, 1, 1, 8'h01, 3, 0, 0));
    tbl.push_back(mk(1, 32'h05060708, 1, 0, 8'h04, 0, 1, 1));
    tbl.push_back(mk(0, 32'h0, 1, 1, 8'h08, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0, 1, 1, 8'h07, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0, 1, 1, 8'h06, 2, 0, 0));
    tbl.push_back(mk(0, 32'h0, 1, 1, 8'h05, 3, 0, 0));
    tbl.push_back(mk(0, 32'h0, 1, 0, 8'h08, 0, 1, 1));
    tbl.push_back(mk(0, 32'h0, 1, 0, 8'h08, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) cyc(0, i, tbl[i]);

    // u1: MSB first, sel returns to 3
    pulse_reset();
    cyc(1, 100, mk(1, 32'hA1B2C3D4, 1, 0, 8'h00, 3, 0, 1));
    cyc(1, 101, mk(0, 32'h0, 1, 1, 8'hA1, 3, 0, 0));
    cyc(1, 102, mk(0, 32'h0, 1, 1, 8'hB2, 2, 0, 0));
    cyc(1, 103, mk(0, 32'h0, 1, 1, 8'hC3, 1, 0, 0));
    cyc(1, 104, mk(0, 32'h0, 1, 1, 8'hD4, 0, 0, 0));
    cyc(1, 105, mk(0, 32'h0, 1, 0, 8'hA1, 3, 1, 1));
    cyc(1, 106, mk(0, 32'h0, 1, 0, 8'hA1, 3, 0, 1));

    // u2: two idle cycles between bytes
    pulse_reset();
    cyc(2, 200, mk(1, 32'h11223344, 1, 0, 8'h00, 0, 0, 1));
    cyc(2, 201, mk(0, 32'h0, 1, 1, 8'h44, 0, 0, 0));
    cyc(2, 202, mk(0, 32'h0, 1, 0, 8'h44, 0, 0, 0));
    cyc(2, 203, mk(0, 32'h0, 1, 0, 8'h44, 0, 0, 0));
    cyc(2, 204, mk(0, 32'h0, 1, 1, 8'h33, 1, 0, 0));
    cyc(2, 205, mk(0, 32'h0, 1, 0, 8'h33, 1, 0, 0));
    cyc(2, 206, mk(0, 32'h0, 1, 0, 8'h33, 1, 0, 0));
    cyc(2, 207, mk(0, 32'h0, 1, 1, 8'h22, 2, 0, 0));
    cyc(2, 208, mk(0, 32'h0, 1, 0, 8'h22, 2, 0, 0));
    cyc(2, 209, mk(0, 32'h0, 1, 0, 8'h22, 2, 0, 0));
    cyc(2, 210, mk(0, 32'h0, 1, 1, 8'h11, 3, 0, 0));
    cyc(2, 211, mk(0, 32'h0, 1, 0, 8'h44, 0, 1, 1));
    cyc(2, 212, mk(0, 32'h0, 1, 0, 8'h44, 0, 0, 1));

    // u0: asynchronous reset mid-word
    pulse_reset();
    cyc(0, 300, mk(1, 32'h55667788, 1, 0, 8'h00, 0, 0, 1));
    cyc(0, 301, mk(0, 32'h0, 1, 1, 8'h88, 0, 0, 0));
    cyc(0, 302, mk(0, 32'h0, 1, 1, 8'h77, 1, 0, 0));
    #2;
    resetn = 1'b0;
    #1;
    outs(0, 303, mk(0, 32'h0, 1, 0, 8'h00, 0, 0, 1));
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 304, mk(0, 32'h0, 1, 0, 8'h00, 0, 0, 1));
    cyc(0, 305, mk(1, 32'h99AABBCC, 1, 0, 8'h00, 0, 0, 1));
    cyc(0, 306, mk(0, 32'h0, 1, 1, 8'hCC, 0, 0, 0));
    cyc(0, 307, mk(0, 32'h0, 1, 1, 8'hBB, 1, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
